// File: rtl/ram_march_bist.sv
// March-test BIST initiator for the dual-port RAM: writes a background pattern,
// reads it back through the opposite port, repeats with the complement, and captures the first miscompare.
module ram_march_bist #(
    parameter int             N   = 4,
    parameter int             D   = 16,
    parameter int             W   = 8,
    parameter logic [W-1:0]   PAT = 8'h55
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         START,
    output logic         CS,
    output logic         WR_RD_A,
    output logic         WR_RD_B,
    output logic [N-1:0] ADDR_A,
    output logic [N-1:0] ADDR_B,
    output logic [W-1:0] WDATA_A,
    output logic [W-1:0] WDATA_B,
    input  logic [W-1:0] RDATA_A,
    input  logic [W-1:0] RDATA_B,
    output logic         BUSY,
    output logic         DONE,
    output logic         FAIL,
    output logic [N-1:0] FAIL_ADDR,
    output logic         FAIL_PORT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_A,
        S_R_B,
        S_W_B,
        S_R_A,
        S_DRAIN
    } state_t;

    localparam logic [N-1:0] LAST = N'(D - 1);

    state_t       state, state_d;
    logic [N-1:0] cnt, cnt_d;

    logic         cs_d, wr_rd_a_d, wr_rd_b_d, busy_d, done_d;
    logic [N-1:0] addr_a_d, addr_b_d;
    logic [W-1:0] wdata_a_d, wdata_b_d;

    logic         rd_vld;
    logic [N-1:0] rd_addr;
    logic         rd_port;
    logic [W-1:0] exp_data;
    logic [W-1:0] rd_data;
    logic         miss;

    // State register and address counter.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Next state: each phase ends when the counter hits its terminal value.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        unique case (state)
            S_IDLE: begin
                if (START) begin
                    state_d = S_W_A;
                    cnt_d   = '0;
                end
            end
            S_W_A: begin
                if (cnt == LAST) begin
                    state_d = S_R_B;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_R_B: begin
                if (cnt == LAST) begin
                    state_d = S_W_B;
                    cnt_d   = LAST;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_W_B: begin
                if (cnt == '0) begin
                    state_d = S_R_A;
                    cnt_d   = LAST;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            S_R_A: begin
                if (cnt == '0) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            S_DRAIN: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: outputs are decoded from the next state so the registered RAM controls line up with the state register.
    always_comb begin
        cs_d      = 1'b1;
        wr_rd_a_d = 1'b0;
        wr_rd_b_d = 1'b0;
        addr_a_d  = '0;
        addr_b_d  = '0;
        wdata_a_d = '0;
        wdata_b_d = '0;
        busy_d    = (state_d != S_IDLE);
        done_d    = (state == S_DRAIN);
        unique case (state_d)
            S_W_A: begin
                cs_d      = 1'b0;
                wr_rd_a_d = 1'b1;
                addr_a_d  = cnt_d;
                wdata_a_d = PAT;
            end
            S_R_B: begin
                cs_d     = 1'b0;
                addr_b_d = cnt_d;
            end
            S_W_B: begin
                cs_d      = 1'b0;
                wr_rd_b_d = 1'b1;
                addr_b_d  = cnt_d;
                wdata_b_d = ~PAT;
            end
            S_R_A: begin
                cs_d     = 1'b0;
                addr_a_d = cnt_d;
            end
            default: begin
                cs_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            CS      <= 1'b1;
            WR_RD_A <= 1'b0;
            WR_RD_B <= 1'b0;
            ADDR_A  <= '0;
            ADDR_B  <= '0;
            WDATA_A <= '0;
            WDATA_B <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            CS      <= cs_d;
            WR_RD_A <= wr_rd_a_d;
            WR_RD_B <= wr_rd_b_d;
            ADDR_A  <= addr_a_d;
            ADDR_B  <= addr_b_d;
            WDATA_A <= wdata_a_d;
            WDATA_B <= wdata_b_d;
            BUSY    <= busy_d;
            DONE    <= done_d;
        end
    end

    // The read tag follows the RAM's one-cycle read latency; the compare happens one edge later.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_vld  <= 1'b0;
            rd_addr <= '0;
            rd_port <= 1'b0;
        end else begin
            rd_vld  <= (state == S_R_B) || (state == S_R_A);
            rd_addr <= cnt;
            rd_port <= (state == S_R_B);
        end
    end

    always_comb begin
        exp_data = rd_port ? PAT : ~PAT;
        rd_data  = rd_port ? RDATA_B : RDATA_A;
        miss     = rd_vld && (rd_data != exp_data);
    end

    // First failure wins; the capture is only cleared by an accepted START.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            FAIL      <= 1'b0;
            FAIL_ADDR <= '0;
            FAIL_PORT <= 1'b0;
        end else if (state == S_IDLE && START) begin
            FAIL      <= 1'b0;
            FAIL_ADDR <= '0;
            FAIL_PORT <= 1'b0;
        end else if (miss && !FAIL) begin
            FAIL      <= 1'b1;
            FAIL_ADDR <= rd_addr;
            FAIL_PORT <= rd_port;
        end
    end

endmodule

// File: tb/tb_ram_march_bist.sv
// Directed bench for ram_march_bist: behavioural dual-port RAM with read-fault injection,
// a table of fault scenarios, plus reset-abort, held-START and reduced-depth sequences.
module tb_ram_march_bist;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // DUT0: default parameters (D=16)
    logic       start0, cs0, wr_a0, wr_b0, busy0, done0, fail0, fail_port0;
    logic [3:0] addr_a0, addr_b0, fail_addr0;
    logic [7:0] wdata_a0, wdata_b0, rdata_a0, rdata_b0;

    // DUT1: D=10
    logic       start1, cs1, wr_a1, wr_b1, busy1, done1, fail1, fail_port1;
    logic [3:0] addr_a1, addr_b1, fail_addr1;
    logic [7:0] wdata_a1, wdata_b1, rdata_a1, rdata_b1;

    logic       fa_en, fb_en;
    logic [3:0] fa_addr, fb_addr;

    logic [7:0] mem0 [16];
    logic [7:0] mem1 [16];

    ram_march_bist dut0 (
        .CLK(clk), .RST_N(rst_n), .START(start0), .CS(cs0),
        .WR_RD_A(wr_a0), .WR_RD_B(wr_b0), .ADDR_A(addr_a0), .ADDR_B(addr_b0),
        .WDATA_A(wdata_a0), .WDATA_B(wdata_b0), .RDATA_A(rdata_a0), .RDATA_B(rdata_b0),
        .BUSY(busy0), .DONE(done0), .FAIL(fail0), .FAIL_ADDR(fail_addr0), .FAIL_PORT(fail_port0)
    );

    ram_march_bist #(.N(4), .D(10)) dut1 (
        .CLK(clk), .RST_N(rst_n), .START(start1), .CS(cs1),
        .WR_RD_A(wr_a1), .WR_RD_B(wr_b1), .ADDR_A(addr_a1), .ADDR_B(addr_b1),
        .WDATA_A(wdata_a1), .WDATA_B(wdata_b1), .RDATA_A(rdata_a1), .RDATA_B(rdata_b1),
        .BUSY(busy1), .DONE(done1), .FAIL(fail1), .FAIL_ADDR(fail_addr1), .FAIL_PORT(fail_port1)
    );

    // RAM model 0: reads flip bit 0 when the port's fault is enabled at the matching address.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem0[i] <= 8'h00;
        end else if (!cs0) begin
            if (wr_a0) mem0[addr_a0] <= wdata_a0;
            else       rdata_a0 <= mem0[addr_a0] ^ {7'd0, (fa_en && addr_a0 == fa_addr)};
            if (wr_b0) mem0[addr_b0] <= wdata_b0;
            else       rdata_b0 <= mem0[addr_b0] ^ {7'd0, (fb_en && addr_b0 == fb_addr)};
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem1[i] <= 8'h00;
        end else if (!cs1) begin
            if (wr_a1) mem1[addr_a1] <= wdata_a1;
            else       rdata_a1 <= mem1[addr_a1];
            if (wr_b1) mem1[addr_b1] <= wdata_b1;
            else       rdata_b1 <= mem1[addr_b1];
        end
    end

    typedef struct {
        string      name;
        bit         fb_en;
        logic [3:0] fb_addr;
        bit         fa_en;
        logic [3:0] fa_addr;
        bit         exp_fail;
        logic [3:0] exp_addr;
        bit         exp_port;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected {CS, WR_RD_A, WR_RD_B, ADDR_A, ADDR_B, WDATA_A, WDATA_B} in busy cycle cyc of a depth-d run.
    function automatic logic [26:0] exp_trace(input int cyc, input int d);
        int         ph, ix;
        logic       cs, wa, wb;
        logic [3:0] aa, ab;
        logic [7:0] da, db;
        ph = cyc / d;
        ix = cyc % d;
        cs = 1'b0; wa = 1'b0; wb = 1'b0;
        aa = 4'd0; ab = 4'd0; da = 8'h00; db = 8'h00;
        case (ph)
            0: begin wa = 1'b1; aa = 4'(ix); da = 8'h55; end
            1: begin ab = 4'(ix); end
            2: begin wb = 1'b1; ab = 4'(d - 1 - ix); db = 8'hAA; end
            3: begin aa = 4'(d - 1 - ix); end
            default: cs = 1'b1;
        endcase
        return {cs, wa, wb, aa, ab, da, db};
    endfunction

    task automatic run_vec(input vec_t v, input bit hold);
        int          cyc, bad, nbad_mem;
        logic [26:0] act, exp;
        fa_en   = v.fa_en;
        fa_addr = v.fa_addr;
        fb_en   = v.fb_en;
        fb_addr = v.fb_addr;
        start0  = 1'b1;
        @(negedge clk);
        if (!hold) start0 = 1'b0;
        check({v.name, "_fail_cleared"}, {31'd0, fail0}, 32'd0);
        cyc = 0;
        bad = 0;
        while (busy0 === 1'b1 && cyc < 200) begin
            act = {cs0, wr_a0, wr_b0, addr_a0, addr_b0, wdata_a0, wdata_b0};
            exp = exp_trace(cyc, 16);
            if (act !== exp || done0 !== 1'b0) begin
                if (bad == 0)
                    $display("  %s: first divergence at busy cycle %0d: got %h done=%b, expected %h", v.name, cyc, act, done0, exp);
                bad++;
            end
            cyc++;
            @(negedge clk);
        end
        check({v.name, "_busy_cycles"}, cyc, 32'd65);
        check({v.name, "_trace_bad_cycles"}, bad, 32'd0);
        check({v.name, "_done"}, {31'd0, done0}, 32'd1);
        check({v.name, "_fail"}, {31'd0, fail0}, {31'd0, v.exp_fail});
        check({v.name, "_fail_addr"}, {28'd0, fail_addr0}, {28'd0, v.exp_addr});
        check({v.name, "_fail_port"}, {31'd0, fail_port0}, {31'd0, v.exp_port});
        nbad_mem = 0;
        for (int i = 0; i < 16; i++) if (mem0[i] !== 8'hAA) nbad_mem++;
        check({v.name, "_mem_bad_words"}, nbad_mem, 32'd0);
        if (!hold) begin
            @(negedge clk);
            check({v.name, "_done_one_cycle"}, {30'd0, done0, busy0}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int          cyc, bad, cnt, nbad, maxa;
        logic [26:0] act;

        vecs = '{
            '{"clean",  1'b0, 4'd0,  1'b0, 4'd0, 1'b0, 4'd0,  1'b0},
            '{"b5",     1'b1, 4'd5,  1'b0, 4'd0, 1'b1, 4'd5,  1'b1},
            '{"b3_a9",  1'b1, 4'd3,  1'b1, 4'd9, 1'b1, 4'd3,  1'b1},
            '{"a0",     1'b0, 4'd0,  1'b1, 4'd0, 1'b1, 4'd0,  1'b0},
            '{"b15",    1'b1, 4'd15, 1'b0, 4'd0, 1'b1, 4'd15, 1'b1},
            '{"a9",     1'b0, 4'd0,  1'b1, 4'd9, 1'b1, 4'd9,  1'b0}
        };

        rst_n   = 1'b0;
        start0  = 1'b0;
        start1  = 1'b0;
        fa_en   = 1'b0;
        fb_en   = 1'b0;
        fa_addr = 4'd0;
        fb_addr = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_cs", {31'd0, cs0}, 32'd1);
        check("rst_busy_done", {30'd0, busy0, done0}, 32'd0);
        check("rst_bus", {5'd0, wr_a0, wr_b0, addr_a0, addr_b0, wdata_a0, wdata_b0}, 32'd0);
        check("rst_fail_info", {26'd0, fail0, fail_addr0, fail_port0}, 32'd0);
        check("rst_cs_d10", {31'd0, cs1}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Fault scenario table, each run started by a one-cycle START pulse.
        for (int i = 0; i < 6; i++) run_vec(vecs[i], 1'b0);

        // Reset in the 10th R_B cycle abandons the run at once.
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (25) @(negedge clk);
        check("midrst_busy_before", {31'd0, busy0}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_cs", {31'd0, cs0}, 32'd1);
        check("midrst_busy", {31'd0, busy0}, 32'd0);
        check("midrst_bus", {5'd0, wr_a0, wr_b0, addr_a0, addr_b0, wdata_a0, wdata_b0}, 32'd0);
        check("midrst_fail_info", {26'd0, fail0, fail_addr0, fail_port0}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done0 !== 1'b0 || busy0 !== 1'b0) cnt++;
        end
        check("midrst_no_done_or_busy", cnt, 32'd0);
        run_vec(vecs[0], 1'b0);

        // START held across a faulty run, then straight into a clean run at the DONE cycle.
        run_vec(vecs[1], 1'b1);
        run_vec(vecs[0], 1'b0);

        // Reduced depth D=10.
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        cyc  = 0;
        bad  = 0;
        maxa = 0;
        while (busy1 === 1'b1 && cyc < 200) begin
            act = {cs1, wr_a1, wr_b1, addr_a1, addr_b1, wdata_a1, wdata_b1};
            if (act !== exp_trace(cyc, 10)) bad++;
            if (int'(addr_a1) > maxa) maxa = int'(addr_a1);
            if (int'(addr_b1) > maxa) maxa = int'(addr_b1);
            cyc++;
            @(negedge clk);
        end
        check("d10_busy_cycles", cyc, 32'd41);
        check("d10_trace_bad_cycles", bad, 32'd0);
        check("d10_max_addr", maxa, 32'd9);
        check("d10_done", {31'd0, done1}, 32'd1);
        check("d10_fail", {31'd0, fail1}, 32'd0);
        nbad = 0;
        for (int i = 0; i < 10; i++) if (mem1[i] !== 8'hAA) nbad++;
        for (int i = 10; i < 16; i++) if (mem1[i] !== 8'h00) nbad++;
        check("d10_mem_bad_words", nbad, 32'd0);
        @(negedge clk);
        check("d10_done_one_cycle", {31'd0, done1}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_march_bist.md
Name: ram_march_bist

Overview:
Built-in self-test initiator for the team's dual-port RAM (active-low chip select, per-port write/read select, one-cycle registered read data). On START it runs a four-phase march test: port A writes, port B reads, port B writes, port A reads. Each read word is compared against the expected background, and the first mismatch is captured. It sits between the system test controller and the RAM, and drives all RAM inputs while BUSY.

Parameters:
N, 4, address width (ADDR_A/ADDR_B)
D, 16, number of words tested, addresses 0..D-1, D <= 2**N
W, 8, data width
PAT, 8'h55 (W bits), background pattern; the complement ~PAT is used in phases 3-4

Ports:
CLK  input  1  clock, all state changes on posedge
RST_N  input  1  asynchronous active-low reset
START  input  1  test request, sampled only in IDLE
CS  output  1  RAM chip select, active low
WR_RD_A  output  1  port A: 1 = write, 0 = read
WR_RD_B  output  1  port B: 1 = write, 0 = read
ADDR_A  output  N  port A address
ADDR_B  output  N  port B address
WDATA_A  output  W  port A write data
WDATA_B  output  W  port B write data
RDATA_A  input  W  port A read data from RAM
RDATA_B  input  W  port B read data from RAM
BUSY  output  1  test in progress
DONE  output  1  one-cycle pulse at test completion
FAIL  output  1  sticky, at least one miscompare in the last run
FAIL_ADDR  output  N  address of the first miscompare
FAIL_PORT  output  1  port of the first miscompare: 0 = A, 1 = B

Behaviour:
- Reset (async, RST_N=0): state IDLE. CS=1, WR_RD_A=WR_RD_B=0, ADDR_A=ADDR_B=0, WDATA_A=WDATA_B=0, BUSY=0, DONE=0, FAIL=0, FAIL_ADDR=0, FAIL_PORT=0. The compare pipeline is cleared.
- All outputs are registered. The RAM acts on the edge ending the cycle in which the outputs are presented.
- IDLE: CS=1. If START=1 at an edge, go to W_A and clear FAIL, FAIL_ADDR and FAIL_PORT. In all other states START is ignored.
- W_A (D cycles): CS=0, WR_RD_A=1, WDATA_A=PAT, ADDR_A=0,1,...,D-1. Port B is idle: WR_RD_B=0, ADDR_B=0.
- R_B (D cycles): WR_RD_B=0, ADDR_B=0..D-1 ascending, expected value PAT. Port A is idle: WR_RD_A=0, ADDR_A=0.
- W_B (D cycles): WR_RD_B=1, WDATA_B=~PAT, ADDR_B=D-1 down to 0. Port A is idle.
- R_A (D cycles): WR_RD_A=0, ADDR_A=D-1 down to 0, expected value ~PAT. Port B is idle.
- DRAIN (1 cycle): CS=1. Lets the final R_A compare complete.
- Then IDLE, with DONE=1 for exactly the first IDLE cycle.
- BUSY=1 in W_A, R_B, W_B, R_A and DRAIN, for 4D+1 cycles total.
- Phase transitions occur when the address counter reaches its terminal value (D-1 ascending, 0 descending). There are no idle cycles between phases.
- Compare pipeline:
  - A read presented in cycle c has its RDATA valid after the edge ending c.
  - At the edge ending c+1, the controller compares RDATA of that port with the expected value.
  - A per-stage valid flag, address and port tag are carried with each read.
  - The last R_B compare occurs during the first W_B cycle. This is legal because the port B write does not update RDATA_B.
  - The last R_A compare occurs in DRAIN.
- Miscompare handling:
  - A miscompare while FAIL=0 sets FAIL=1 and captures FAIL_ADDR and FAIL_PORT.
  - Later miscompares are counted as failures but do not overwrite the captured values (first failure wins).
  - The test always runs to completion, and the cycle count is independent of failures.
- FAIL, FAIL_ADDR and FAIL_PORT hold their values in IDLE until the next accepted START or reset.
- Reset mid-test: the test is abandoned immediately and all outputs take their reset values. No DONE is generated. RAM contents are undefined and are not restored.
- Width rules:
  - Address counters are N bits. D < 2**N is legal; the counters never exceed D-1.
  - Inactive-port ADDR and WDATA are driven to 0.

Test Plan:
1. Default parameters, fault-free RAM model; pulse START for 1 cycle -> BUSY high 65 cycles, then DONE for 1 cycle, FAIL=0. Port A writes 0x55 to addresses 0..15; port B writes 0xAA to addresses 15..0.
2. RAM model flips RDATA_B bit 0 on the read of address 5 -> FAIL=1, FAIL_ADDR=5, FAIL_PORT=1. DONE still arrives 65 cycles after START.
3. Faults injected at R_B address 3 and R_A address 9 -> FAIL_ADDR=3, FAIL_PORT=1. The port A fault does not overwrite the first capture.
4. RST_N pulled low in the 10th cycle of R_B -> CS=1 and BUSY=0 without waiting for a clock edge, and no DONE. A new START then runs the full 65-cycle test with FAIL=0.
5. START held high through the whole run -> no restart while BUSY. After DONE, the next IDLE edge with START=1 starts a new run and clears the FAIL left by a prior faulty run.
6. Parameters D=10, N=4 -> addresses limited to 0..9, BUSY high 41 cycles, ADDR never exceeds 9.
